// File: rtl/image_stream_loader.sv
// Purpose : loads one framed image (HDR, N_PIX pixels, label) from a byte stream into the
//           image buffer, runs the accelerator, and reports digit vs label with running counts.
// Latency : N_PIX+2 accepted bytes, 1 START cycle, WAIT (done edge or TIMEOUT), 1 REPORT cycle.
// Backpr. : s_ready high only in IDLE/LOAD/LABEL; producer holds s_data while s_valid && !s_ready.
// Ports   : clk/rst (sync, active-low); s_data/s_valid/s_ready byte stream in;
//           img_we/img_addr/img_wdata buffer write; acc_start/acc_done/acc_digit accelerator;
//           res_* result (valid with res_valid); frame_err; cnt_total/cnt_pass; busy.
module image_stream_loader #(
   parameter int         N_PIX   = 784,
   parameter int         TIMEOUT = 5000,
   parameter logic [7:0] HDR     = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        img_we,
   output logic [9:0]  img_addr,
   output logic [7:0]  img_wdata,
   output logic        acc_start,
   input  logic        acc_done,
   input  logic [3:0]  acc_digit,
   output logic        res_valid,
   output logic [3:0]  res_digit,
   output logic [3:0]  res_label,
   output logic        res_match,
   output logic        res_timeout,
   output logic        frame_err,
   output logic [15:0] cnt_total,
   output logic [15:0] cnt_pass,
   output logic        busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, LABEL, START, WAIT, REPORT
   } state_t;

   state_t         state;
   logic [9:0]     pix_cnt;
   logic [TW-1:0]  tcnt;
   logic [3:0]     label_q;
   logic           acc_done_q;

   logic           xfer;
   logic           label_ok;
   logic           done_rise;
   logic           tmo_hit;
   logic           fin_match;

   // Ready is forced low while reset is asserted, not just after the reset edge.
   assign s_ready   = rst && (state == IDLE || state == LOAD || state == LABEL);
   assign busy      = (state != IDLE);
   assign xfer      = s_valid && s_ready;
   assign label_ok  = (s_data[7:4] == 4'd0) && (s_data[3:0] <= 4'd9);

   // Only a fresh 0->1 transition counts; a level left high by a previous run is ignored.
   assign done_rise = acc_done && !acc_done_q;
   // tcnt is cleared on WAIT entry, so this fires on the TIMEOUT-th WAIT cycle.
   assign tmo_hit   = (tcnt == TW'(TIMEOUT - 1));
   // A done edge wins over a simultaneous timeout.
   assign fin_match = done_rise && (acc_digit == label_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         pix_cnt     <= '0;
         tcnt        <= '0;
         label_q     <= '0;
         acc_done_q  <= 1'b0;
         img_we      <= 1'b0;
         img_addr    <= '0;
         img_wdata   <= '0;
         acc_start   <= 1'b0;
         res_valid   <= 1'b0;
         res_digit   <= '0;
         res_label   <= '0;
         res_match   <= 1'b0;
         res_timeout <= 1'b0;
         frame_err   <= 1'b0;
         cnt_total   <= '0;
         cnt_pass    <= '0;
      end else begin
         acc_done_q <= acc_done;
         img_we     <= 1'b0;
         acc_start  <= 1'b0;
         res_valid  <= 1'b0;
         frame_err  <= 1'b0;

         case (state)
            IDLE: begin
               if (xfer) begin
                  if (s_data == HDR) begin
                     pix_cnt <= '0;
                     state   <= LOAD;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (xfer) begin
                  img_we    <= 1'b1;
                  img_addr  <= pix_cnt;
                  img_wdata <= s_data;
                  if (pix_cnt == 10'(N_PIX - 1)) begin
                     state <= LABEL;
                  end else begin
                     pix_cnt <= pix_cnt + 10'd1;
                  end
               end
            end
            LABEL: begin
               if (xfer) begin
                  if (label_ok) begin
                     // Kept internally so the published res_label still belongs to the
                     // previous result until this frame reaches REPORT.
                     label_q   <= s_data[3:0];
                     acc_start <= 1'b1;
                     state     <= START;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            START: begin
               tcnt  <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (done_rise || tmo_hit) begin
                  res_valid   <= 1'b1;
                  res_digit   <= done_rise ? acc_digit : 4'hF;
                  res_timeout <= !done_rise;
                  res_label   <= label_q;
                  res_match   <= fin_match;
                  if (cnt_total != 16'hFFFF) cnt_total <= cnt_total + 16'd1;
                  if (fin_match && cnt_pass != 16'hFFFF) cnt_pass <= cnt_pass + 16'd1;
                  state <= REPORT;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            REPORT: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
